// File: rtl/game_scoreboard_pkg.sv
// Shared types and helpers for the whack-a-mole scoreboard.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  // Code the downstream 7-segment driver renders with all segments off.
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  // Split a 0..99 second count into {tens, units} BCD digits.
  function automatic logic [7:0] to_bcd2(input int seconds);
    logic [7:0] bcd;
    bcd[7:4] = 4'(seconds / 10);
    bcd[3:0] = 4'(seconds % 10);
    return bcd;
  endfunction

endpackage

// File: rtl/game_scoreboard_bcd_counter.sv
// Multi-digit BCD up-counter with carry ripple, synchronous clear and
// saturation at all nines.
module bcd_counter
  import game_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   value
);

  logic [4*DIGITS-1:0] value_d;
  logic                all_nine;
  logic                carry;

  // Next value: ripple +1 through the digits, hold when already all nines.
  always_comb begin
    value_d  = value;
    all_nine = 1'b1;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (value[4*i +: 4] != 4'd9) begin
        all_nine = 1'b0;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == 4'd9) begin
          value_d[4*i +: 4] = 4'd0;
        end else begin
          value_d[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    if (all_nine) begin
      value_d = value;
    end
  end

  // Counter register; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= value_d;
    end
  end

endmodule

// File: rtl/game_scoreboard.sv
// Whack-a-mole score and countdown engine. Produces eight BCD digits
// (time, misses, score) for the 7-segment driver plus game status flags.
module game_scoreboard
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int GAME_SECONDS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] display7,
  output logic [3:0] display6,
  output logic [3:0] display5,
  output logic [3:0] display4,
  output logic [3:0] display3,
  output logic [3:0] display2,
  output logic [3:0] display1,
  output logic [3:0] display0,
  output logic       running,
  output logic       game_over,
  output logic       sec_tick
);

  localparam int               PRE_W    = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_HZ - 1);
  localparam logic [7:0]       GAME_BCD = to_bcd2(GAME_SECONDS);

  state_t           state_q;
  state_t           state_d;
  logic [PRE_W-1:0] prescaler;
  logic [3:0]       time_tens;
  logic [3:0]       time_units;
  logic [15:0]      score;
  logic [7:0]       misses;
  logic             in_run;
  logic             launch;
  logic             tick;
  logic             time_last;

  assign in_run    = (state_q == RUN);
  // A start outside RUN begins a game; a start during RUN is ignored.
  assign launch    = start && !in_run;
  assign tick      = in_run && (prescaler == PRE_MAX);
  assign time_last = (time_tens == 4'd0) && (time_units == 4'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the tick leaving 01 ends the game.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (tick && time_last) state_d = OVER;
      OVER:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Status flags registered from the next state so they change on the
  // same edge as the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b0;
      game_over <= 1'b0;
      sec_tick  <= 1'b0;
    end else begin
      running   <= (state_d == RUN);
      game_over <= (state_d == OVER);
      sec_tick  <= tick;
    end
  end

  // One-second prescaler, free-running only while a game is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (launch) begin
      prescaler <= '0;
    end else if (in_run) begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
    end
  end

  // Remaining-time countdown with BCD borrow from tens into units.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_tens  <= GAME_BCD[7:4];
      time_units <= GAME_BCD[3:0];
    end else if (launch) begin
      time_tens  <= GAME_BCD[7:4];
      time_units <= GAME_BCD[3:0];
    end else if (tick) begin
      if (time_units == 4'd0) begin
        time_units <= 4'd9;
        time_tens  <= time_tens - 4'd1;
      end else begin
        time_units <= time_units - 4'd1;
      end
    end
  end

  bcd_counter #(
    .DIGITS (4)
  ) u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hit && in_run),
    .clr   (launch),
    .value (score)
  );

  bcd_counter #(
    .DIGITS (2)
  ) u_misses (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (miss && in_run),
    .clr   (launch),
    .value (misses)
  );

  assign display7 = time_tens;
  assign display6 = time_units;
  assign display5 = misses[7:4];
  assign display4 = misses[3:0];
  assign display3 = score[15:12];
  assign display2 = score[11:8];
  assign display1 = score[7:4];
  assign display0 = score[3:0];

endmodule

// File: tb/tb_game_scoreboard.sv
// Bench for game_scoreboard: a short-game instance (CLK_HZ=4, 3 s) and a
// long-game instance (CLK_HZ=1000, 60 s), both compared every cycle with an
// integer-arithmetic model of the game rules, plus directed checkpoints.
module tb_game_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n_a, rst_n_b;
  logic        st_a, ht_a, ms_a;
  logic        st_b, ht_b, ms_b;
  logic [31:0] dig_a, dig_b;
  logic        run_a, ovr_a, tck_a;
  logic        run_b, ovr_b, tck_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state, index 0 = short game, 1 = long game.
  int m_clk[2];
  int m_gs[2];
  int m_elapsed[2];
  int m_score[2];
  int m_miss[2];
  bit m_run[2];
  bit m_over[2];
  bit m_tick[2];

  always #5 clk = ~clk;

  game_scoreboard #(.CLK_HZ(4), .GAME_SECONDS(3)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(st_a), .hit(ht_a), .miss(ms_a),
    .display7(dig_a[31:28]), .display6(dig_a[27:24]),
    .display5(dig_a[23:20]), .display4(dig_a[19:16]),
    .display3(dig_a[15:12]), .display2(dig_a[11:8]),
    .display1(dig_a[7:4]),   .display0(dig_a[3:0]),
    .running(run_a), .game_over(ovr_a), .sec_tick(tck_a)
  );

  game_scoreboard #(.CLK_HZ(1000), .GAME_SECONDS(60)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(st_b), .hit(ht_b), .miss(ms_b),
    .display7(dig_b[31:28]), .display6(dig_b[27:24]),
    .display5(dig_b[23:20]), .display4(dig_b[19:16]),
    .display3(dig_b[15:12]), .display2(dig_b[11:8]),
    .display1(dig_b[7:4]),   .display0(dig_b[3:0]),
    .running(run_b), .game_over(ovr_b), .sec_tick(tck_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_elapsed[d] = 0;
    m_score[d]   = 0;
    m_miss[d]    = 0;
    m_run[d]     = 1'b0;
    m_over[d]    = 1'b0;
    m_tick[d]    = 1'b0;
  endtask

  // Game rules applied once per clock edge.
  task automatic model_step(input int d, input logic s, input logic h, input logic mi);
    m_tick[d] = 1'b0;
    if (m_run[d]) begin
      if (h && m_score[d] < 9999) m_score[d]++;
      if (mi && m_miss[d] < 99) m_miss[d]++;
      m_elapsed[d]++;
      if (m_elapsed[d] % m_clk[d] == 0) m_tick[d] = 1'b1;
      if (m_elapsed[d] == m_gs[d] * m_clk[d]) begin
        m_run[d]  = 1'b0;
        m_over[d] = 1'b1;
      end
    end else if (s) begin
      m_run[d]     = 1'b1;
      m_over[d]    = 1'b0;
      m_score[d]   = 0;
      m_miss[d]    = 0;
      m_elapsed[d] = 0;
    end
  endtask

  function automatic logic [31:0] exp_digits(input int d);
    int s, m, c;
    s = m_gs[d] - m_elapsed[d] / m_clk[d];
    m = m_miss[d];
    c = m_score[d];
    return {4'(s / 10), 4'(s % 10), 4'(m / 10), 4'(m % 10),
            4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic check_models();
    chk("a_digits", dig_a, exp_digits(0));
    chk("a_flags", {29'd0, run_a, ovr_a, tck_a}, {29'd0, m_run[0], m_over[0], m_tick[0]});
    chk("b_digits", dig_b, exp_digits(1));
    chk("b_flags", {29'd0, run_b, ovr_b, tck_b}, {29'd0, m_run[1], m_over[1], m_tick[1]});
  endtask

  // One clock: inputs already driven, model follows the edge, sample 1 ns later.
  task automatic step();
    @(posedge clk);
    model_step(0, st_a, ht_a, ms_a);
    model_step(1, st_b, ht_b, ms_b);
    #1;
    check_models();
    st_a = 1'b0; ht_a = 1'b0; ms_a = 1'b0;
    st_b = 1'b0; ht_b = 1'b0; ms_b = 1'b0;
  endtask

  initial begin
    m_clk[0] = 4;    m_gs[0] = 3;
    m_clk[1] = 1000; m_gs[1] = 60;
    model_reset(0);
    model_reset(1);
    st_a = 1'b0; ht_a = 1'b0; ms_a = 1'b0;
    st_b = 1'b0; ht_b = 1'b0; ms_b = 1'b0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    #22;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    #1;
    chk("reset_b_digits", dig_b, 32'h6000_0000);
    chk("reset_a_digits", dig_a, 32'h0300_0000);
    chk("reset_b_flags", {29'd0, run_b, ovr_b, tck_b}, 32'd0);
    check_models();

    // Short game: ticks at cycles 4, 8, 12; hit on the final-tick cycle.
    st_a = 1'b1;
    step();
    chk("a_start_run", {31'd0, run_a}, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      if (k == 12) ht_a = 1'b1;
      step();
      chk("a_tick_cycle", {31'd0, tck_a}, {31'd0, (k % 4) == 0});
    end
    chk("a_end_flags", {30'd0, run_a, ovr_a}, 32'd1);
    chk("a_final_hit", dig_a, 32'h0000_0001);
    ht_a = 1'b1;
    step();
    chk("a_over_hit_ignored", dig_a, 32'h0000_0001);
    st_a = 1'b1;
    ht_a = 1'b1;
    step();
    chk("a_restart", {dig_a[31:1], run_a}, {31'h0180_0000, 1'b1});

    // Hit every cycle until time reads 02, then async reset between edges.
    for (int k = 0; k < 5; k++) begin
      ht_a = 1'b1;
      step();
    end
    chk("a_pre_reset_time", {24'd0, dig_a[31:24]}, 32'h0000_0002);
    #3;
    rst_n_a = 1'b0;
    #1;
    chk("a_async_reset", {dig_a, 3'b000} ^ {32'h0300_0000, run_a, ovr_a, tck_a}, 35'd0);
    model_reset(0);
    #2;
    rst_n_a = 1'b1;

    // Randomized play on the short game across several starts.
    for (int k = 0; k < 400; k++) begin
      st_a = ($urandom_range(0, 15) == 0);
      ht_a = 1'($urandom_range(0, 1));
      ms_a = ($urandom_range(0, 3) == 0);
      step();
    end

    // Long game: counters, carries and saturation.
    st_b = 1'b1;
    ht_b = 1'b1;
    step();
    chk("b_start_drops_hit", dig_b, 32'h6000_0000);
    for (int k = 0; k < 10; k++) begin
      ht_b = 1'b1; ms_b = 1'b1;
      step();
    end
    chk("b_hit_miss_10", {8'd0, dig_b[23:0]}, 32'h0010_0010);
    for (int k = 0; k < 90; k++) begin
      ht_b = 1'b1;
      step();
    end
    chk("b_score_0100", {16'd0, dig_b[15:0]}, 32'h0000_0100);
    for (int k = 0; k < 89; k++) begin
      ms_b = 1'b1;
      step();
    end
    chk("b_miss_99", {24'd0, dig_b[23:16]}, 32'h0000_0099);
    ms_b = 1'b1;
    step();
    chk("b_miss_sat", {24'd0, dig_b[23:16]}, 32'h0000_0099);
    for (int k = 0; k < 9898; k++) begin
      ht_b = 1'b1;
      step();
    end
    chk("b_score_9998", {16'd0, dig_b[15:0]}, 32'h0000_9998);
    for (int k = 0; k < 3; k++) begin
      ht_b = 1'b1;
      step();
    end
    chk("b_score_sat", {16'd0, dig_b[15:0]}, 32'h0000_9999);
    chk("b_still_running", {31'd0, run_b}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
